// File: rtl/lenet_pkg.sv
// Shared constants and FSM state type for the lenet post-processing blocks.
package lenet_pkg;

  localparam int unsigned ACT_FC2_BASE      = 743;
  localparam int unsigned ACT_RESULT_ADDR   = 753;
  localparam int unsigned LENET_NUM_CLASSES = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WB,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/lenet_argmax.sv
// Scans the FC2 logits in activation SRAM and reports the argmax class and its value.
// Optional result write-back to RESULT_ADDR is enabled by defining LENET_ARGMAX_WB_EN.
module lenet_argmax
  import lenet_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CLASSES = LENET_NUM_CLASSES,
  parameter int unsigned BASE_ADDR   = ACT_FC2_BASE,
  parameter int unsigned RESULT_ADDR = ACT_RESULT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        class_idx,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] sram_act_addr,
  output logic [3:0]        sram_act_wea,
  output logic [DATA_W-1:0] sram_act_wdata,
  input  logic [DATA_W-1:0] sram_act_rdata
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  if ((NUM_CLASSES < 2) || (NUM_CLASSES > 16) || ((RESULT_ADDR >> ADDR_W) != 0)) begin : g_cfg_err
    $error("lenet_argmax: unsupported parameter combination");
  end

  argmax_state_t     state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              tag_vld_q;
  logic [IDX_W-1:0]  tag_idx_q;
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic              busy_q, done_q;
  logic [IDX_W-1:0]  class_idx_q;
  logic [DATA_W-1:0] max_val_q;
  logic [ADDR_W-1:0] addr_q;
  logic              take;

  // Word 0 seeds the running max; later words win only when strictly greater.
  always_comb begin
    take      = tag_vld_q &&
                ((tag_idx_q == '0) || ($signed(sram_act_rdata) > $signed(run_max_q)));
    run_max_d = take ? sram_act_rdata : run_max_q;
    run_idx_d = take ? tag_idx_q      : run_idx_q;
  end

`ifdef LENET_ARGMAX_WB_EN
  logic [3:0]        wea_q;
  logic [DATA_W-1:0] wdata_q;
  assign sram_act_wea   = wea_q;
  assign sram_act_wdata = wdata_q;
`else
  assign sram_act_wea   = '0;
  assign sram_act_wdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tag_vld_q   <= 1'b0;
      tag_idx_q   <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      addr_q      <= '0;
`ifdef LENET_ARGMAX_WB_EN
      wea_q       <= '0;
      wdata_q     <= '0;
`endif
    end else begin
      tag_vld_q <= 1'b0;
      done_q    <= 1'b0;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
          end
        end
        FETCH: begin
          tag_vld_q <= 1'b1;
          tag_idx_q <= cnt_q;
          if (cnt_q == LAST) begin
            state_q <= DRAIN;
            addr_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= ADDR_W'(BASE_ADDR + 32'(cnt_q) + 1);
          end
        end
        DRAIN: begin
`ifdef LENET_ARGMAX_WB_EN
          state_q <= WB;
          addr_q  <= ADDR_W'(RESULT_ADDR);
          wea_q   <= 4'hF;
          wdata_q <= DATA_W'(run_idx_d);
`else
          state_q     <= DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          class_idx_q <= run_idx_d;
          max_val_q   <= run_max_d;
`endif
        end
`ifdef LENET_ARGMAX_WB_EN
        WB: begin
          state_q     <= DONE;
          addr_q      <= '0;
          wea_q       <= '0;
          wdata_q     <= '0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          class_idx_q <= run_idx_d;
          max_val_q   <= run_max_d;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign class_idx     = class_idx_q;
  assign max_val       = max_val_q;
  assign sram_act_addr = addr_q;

endmodule

// File: tb/tb_lenet_argmax.sv
// Self-checking bench for lenet_argmax with a behavioural SRAM and argmax reference model.
module tb_lenet_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic [3:0]  class_idx;
  logic [31:0] max_val;
  logic [15:0] sram_act_addr;
  logic [3:0]  sram_act_wea;
  logic [31:0] sram_act_wdata;
  logic [31:0] sram_act_rdata = '0;

`ifdef LENET_ARGMAX_WB_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int DONE_K = WB ? 13 : 12;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] cur [10];

  always #5 clk = ~clk;

  lenet_argmax dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .class_idx      (class_idx),
    .max_val        (max_val),
    .sram_act_addr  (sram_act_addr),
    .sram_act_wea   (sram_act_wea),
    .sram_act_wdata (sram_act_wdata),
    .sram_act_rdata (sram_act_rdata)
  );

  always @(posedge clk) begin
    sram_act_rdata <= mem[sram_act_addr[9:0]];
    for (int b = 0; b < 4; b++)
      if (sram_act_wea[b]) mem[sram_act_addr[9:0]][8*b +: 8] <= sram_act_wdata[8*b +: 8];
  end

  function automatic void ref_argmax(output int unsigned idx, output logic [31:0] mx);
    idx = 0;
    mx  = cur[0];
    for (int i = 1; i < 10; i++)
      if ($signed(cur[i]) > $signed(mx)) begin
        idx = i;
        mx  = cur[i];
      end
  endfunction

  task automatic load_scenario1();
    logic [31:0] s [10];
    s = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd0, 32'd99, -32'sd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 10; i++) cur[i] = s[i];
  endtask

  // Issues one start at the current negedge and observes 40 cycles.
  task automatic run_case(input string name, input int extra_k);
    int unsigned eidx;
    logic [31:0] emax, prev_max;
    logic [3:0]  prev_idx;
    int          done_k, busy_n, extra_done;
    bit          seq_ok, hold_ok, ram_ok;
    ref_argmax(eidx, emax);
    for (int i = 0; i < 10; i++) mem[743+i] = cur[i];
    mem[753]   = SENTINEL;
    prev_idx   = class_idx;
    prev_max   = max_val;
    done_k     = 0;
    busy_n     = 0;
    extra_done = 0;
    seq_ok     = 1'b1;
    hold_ok    = 1'b1;
    start      = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        if (done_k == 0) done_k = k;
        else extra_done++;
      end
      if (k <= 10 && (sram_act_addr !== 16'(743 + k - 1) || sram_act_wea !== 4'h0)) seq_ok = 1'b0;
      if (k == 11 && sram_act_addr !== 16'd0) seq_ok = 1'b0;
      if (WB && k == 12 &&
          (sram_act_addr !== 16'd753 || sram_act_wea !== 4'hF || sram_act_wdata !== 32'(eidx)))
        seq_ok = 1'b0;
      if (!WB && (sram_act_wea !== 4'h0 || sram_act_wdata !== 32'h0)) seq_ok = 1'b0;
      if (done_k == 0 && (class_idx !== prev_idx || max_val !== prev_max)) hold_ok = 1'b0;
      start = (extra_k != 0 && k == extra_k);
    end
    start = 1'b0;

    n_checks++;
    if (done_k !== DONE_K) $display("FAIL %s done_cycle: got %0d want %0d", name, done_k, DONE_K);
    else n_pass++;
    n_checks++;
    if (busy_n !== DONE_K - 1) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, DONE_K - 1);
    else n_pass++;
    n_checks++;
    if (extra_done !== 0) $display("FAIL %s extra_done: got %0d want 0", name, extra_done);
    else n_pass++;
    n_checks++;
    if (!seq_ok) $display("FAIL %s sram_sequence: got bad want ok", name);
    else n_pass++;
    n_checks++;
    if (!hold_ok) $display("FAIL %s hold_before_done: got changed want held", name);
    else n_pass++;
    n_checks++;
    if (class_idx !== 4'(eidx)) $display("FAIL %s class_idx: got %0d want %0d", name, class_idx, eidx);
    else n_pass++;
    n_checks++;
    if (max_val !== emax) $display("FAIL %s max_val: got %h want %h", name, max_val, emax);
    else n_pass++;
    ram_ok = (mem[753] === (WB ? 32'(eidx) : SENTINEL));
    for (int i = 0; i < 10; i++) if (mem[743+i] !== cur[i]) ram_ok = 1'b0;
    n_checks++;
    if (!ram_ok) $display("FAIL %s ram_contents: got word753=%h want %h", name, mem[753],
                          WB ? 32'(eidx) : SENTINEL);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, class_idx, max_val, sram_act_addr, sram_act_wea, sram_act_wdata} !== '0)
      $display("FAIL reset_values: got busy=%b done=%b idx=%0d max=%h addr=%0d wea=%h wdata=%h want all 0",
               busy, done, class_idx, max_val, sram_act_addr, sram_act_wea, sram_act_wdata);
    else n_pass++;
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_start_ignored: got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    load_scenario1();
    run_case("scenario1", 0);
  endtask

  task automatic test_all_min();
    for (int i = 0; i < 10; i++) cur[i] = 32'h8000_0000;
    run_case("all_min", 0);
  endtask

  task automatic test_max_last();
    for (int i = 0; i < 9; i++) cur[i] = -32'sd5;
    cur[9] = 32'h7FFF_FFFF;
    run_case("max_last", 0);
  endtask

  task automatic test_ignore_start();
    load_scenario1();
    run_case("ignore_start", 4);
  endtask

  task automatic test_rst_abort();
    int  done_seen;
    bit  busy_seen;
    load_scenario1();
    for (int i = 0; i < 10; i++) mem[743+i] = cur[i];
    mem[753] = SENTINEL;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, class_idx, max_val, sram_act_addr, sram_act_wea, sram_act_wdata} !== '0)
      $display("FAIL abort_outputs: got busy=%b done=%b idx=%0d max=%h addr=%0d wea=%h want all 0",
               busy, done, class_idx, max_val, sram_act_addr, sram_act_wea);
    else n_pass++;
    rst       = 1'b0;
    done_seen = 0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen = 1'b1;
    end
    n_checks++;
    if (done_seen != 0 || busy_seen || mem[753] !== SENTINEL)
      $display("FAIL abort_no_result: got done=%0d busy=%b word753=%h want 0 0 %h",
               done_seen, busy_seen, mem[753], SENTINEL);
    else n_pass++;
    for (int i = 0; i < 10; i++) cur[i] = 32'(-50 + int'($urandom_range(0, 9)));
    run_case("post_abort", 0);
  endtask

  task automatic test_random();
    logic [31:0] ext [4];
    ext = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 10; i++) begin
        case (r % 3)
          0:       cur[i] = $urandom;
          1:       cur[i] = 32'(int'($urandom_range(0, 3)) - 2);
          default: cur[i] = ext[$urandom_range(0, 3)];
        endcase
      end
      run_case($sformatf("random%0d", r), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'h5A5A_0000;
    @(negedge clk);
    test_reset();
    test_directed();
    test_all_min();
    test_max_last();
    test_ignore_start();
    test_rst_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
